// File: rtl/collate_pkg.sv
// Shared defaults and record types for the multi-wavefront instruction collator.
// Widths here are the defaults; the modules carry their own parameterised copies.
package collate_pkg;

  localparam int DEF_NUM_WF  = 40;
  localparam int DEF_WFID_W  = 6;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_PC_STEP = 4;

  typedef struct packed {
    logic                   pending;
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc;
  } slot_rec_t;

  typedef struct packed {
    logic [DEF_WFID_W-1:0]    wfid;
    logic [2*DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]      pc;
    logic                     long_instr;
  } out_rec_t;

  // How an accepted word is treated once its slot state is known.
  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_SHORT,
    KIND_FIRST,
    KIND_SECOND
  } word_kind_t;

endpackage

// File: rtl/collate_slot_store.sv
// Per-wavefront first-half storage: data array, pending bits and a running
// count of pending slots. Callers keep set/clear and flush on distinct slots.
module collate_slot_store
  import collate_pkg::*;
#(
  parameter int NUM_WF  = DEF_NUM_WF,
  parameter int WFID_W  = DEF_WFID_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = $clog2(DEF_NUM_WF + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WFID_W-1:0]  rd_idx,
  output logic               rd_pending,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [PC_W-1:0]    rd_pc,
  input  logic               wr_set,
  input  logic               wr_clr,
  input  logic [WFID_W-1:0]  wr_idx,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic [PC_W-1:0]    wr_pc,
  input  logic               flush_en,
  input  logic [WFID_W-1:0]  flush_idx,
  output logic [CNT_W-1:0]   pending_count
);

  logic [NUM_WF-1:0]  pending;
  logic [INSTR_W-1:0] instr_mem [NUM_WF];
  logic [PC_W-1:0]    pc_mem    [NUM_WF];
  logic               clr_dec;
  logic               flush_dec;

  assign rd_pending = pending[rd_idx];
  assign rd_instr   = instr_mem[rd_idx];
  assign rd_pc      = pc_mem[rd_idx];

  // Only count slots that actually transition from pending to clear.
  assign clr_dec   = wr_clr & pending[wr_idx];
  assign flush_dec = flush_en & pending[flush_idx] & ~(wr_clr && (wr_idx == flush_idx));

  // NOTE: slot data is qualified by its pending bit, so the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_set) begin
      instr_mem[wr_idx] <= wr_instr;
      pc_mem[wr_idx]    <= wr_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      if (wr_set)   pending[wr_idx]    <= 1'b1;
      if (wr_clr)   pending[wr_idx]    <= 1'b0;
      if (flush_en) pending[flush_idx] <= 1'b0;
      pending_count <= pending_count + CNT_W'(wr_set) - CNT_W'(clr_dec) - CNT_W'(flush_dec);
    end
  end

endmodule

// File: rtl/wf_instr_collator.sv
// Multi-wavefront 64-bit instruction collator: classifies accepted words,
// pairs first and second halves per wavefront and presents them downstream.
module wf_instr_collator
  import collate_pkg::*;
#(
  parameter int NUM_WF  = DEF_NUM_WF,
  parameter int WFID_W  = DEF_WFID_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WFID_W-1:0]            in_wfid,
  input  logic [INSTR_W-1:0]           in_instr,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         in_long,
  input  logic                         flush_valid,
  input  logic [WFID_W-1:0]            flush_wfid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WFID_W-1:0]            out_wfid,
  output logic [2*INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_long,
  output logic                         half_rqd,
  output logic [WFID_W-1:0]            half_rqd_wfid,
  output logic                         err_pc,
  output logic [$clog2(NUM_WF+1)-1:0]  pending_count
);

  localparam int CNT_W   = $clog2(NUM_WF + 1);
  localparam int LIMIT_W = WFID_W + 1;
  localparam logic [LIMIT_W-1:0] WF_LIMIT = LIMIT_W'(NUM_WF);

  logic               accept;
  logic               in_ok;
  logic               flush_ok;
  logic               flush_same;
  logic               out_drop;
  logic               rd_pending;
  logic [INSTR_W-1:0] rd_instr;
  logic [PC_W-1:0]    rd_pc;
  logic [PC_W-1:0]    pc_expected;
  word_kind_t         kind;

  assign in_ready    = ~out_valid | out_ready;
  assign accept      = in_valid & in_ready;
  assign in_ok       = {1'b0, in_wfid} < WF_LIMIT;
  assign flush_ok    = flush_valid & ({1'b0, flush_wfid} < WF_LIMIT);
  assign flush_same  = flush_ok & (flush_wfid == in_wfid);
  assign out_drop    = flush_ok & out_valid & (out_wfid == flush_wfid);
  assign pc_expected = rd_pc + PC_W'(PC_STEP);

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    kind = KIND_NONE;
    if (accept && in_ok && !flush_same) begin
      if (rd_pending)   kind = KIND_SECOND;
      else if (in_long) kind = KIND_FIRST;
      else              kind = KIND_SHORT;
    end
  end

  collate_slot_store #(
    .NUM_WF  (NUM_WF),
    .WFID_W  (WFID_W),
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) u_slots (
    .clk           (clk),
    .rst           (rst),
    .rd_idx        (in_wfid),
    .rd_pending    (rd_pending),
    .rd_instr      (rd_instr),
    .rd_pc         (rd_pc),
    .wr_set        (kind == KIND_FIRST),
    .wr_clr        (kind == KIND_SECOND),
    .wr_idx        (in_wfid),
    .wr_instr      (in_instr),
    .wr_pc         (in_pc),
    .flush_en      (flush_ok),
    .flush_idx     (flush_wfid),
    .pending_count (pending_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_wfid      <= '0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_long      <= 1'b0;
      half_rqd      <= 1'b0;
      half_rqd_wfid <= '0;
      err_pc        <= 1'b0;
    end else begin
      half_rqd <= (kind == KIND_FIRST);
      err_pc   <= (kind == KIND_SECOND) && (in_pc != pc_expected);
      if (kind == KIND_FIRST) half_rqd_wfid <= in_wfid;

      // A load implies in_ready, so any previous output is gone or consumed.
      if (kind == KIND_SHORT) begin
        out_valid <= 1'b1;
        out_wfid  <= in_wfid;
        out_instr <= {{INSTR_W{1'b0}}, in_instr};
        out_pc    <= in_pc;
        out_long  <= 1'b0;
      end else if (kind == KIND_SECOND) begin
        out_valid <= 1'b1;
        out_wfid  <= in_wfid;
        out_instr <= {in_instr, rd_instr};
        out_pc    <= rd_pc;
        out_long  <= 1'b1;
      end else if (out_ready || out_drop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wf_instr_collator.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a per-wavefront reference model built from the collation rules.
module tb_wf_instr_collator;

  localparam int NUM_WF  = 40;
  localparam int WFID_W  = 6;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;
  localparam int CNT_W   = $clog2(NUM_WF + 1);

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WFID_W-1:0]    in_wfid;
  logic [INSTR_W-1:0]   in_instr;
  logic [PC_W-1:0]      in_pc;
  logic                 in_long;
  logic                 flush_valid;
  logic [WFID_W-1:0]    flush_wfid;
  logic                 out_valid;
  logic                 out_ready;
  logic [WFID_W-1:0]    out_wfid;
  logic [2*INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]      out_pc;
  logic                 out_long;
  logic                 half_rqd;
  logic [WFID_W-1:0]    half_rqd_wfid;
  logic                 err_pc;
  logic [CNT_W-1:0]     pending_count;

  wf_instr_collator #(
    .NUM_WF (NUM_WF), .WFID_W (WFID_W), .INSTR_W (INSTR_W), .PC_W (PC_W), .PC_STEP (PC_STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wfid       (in_wfid),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_long       (in_long),
    .flush_valid   (flush_valid),
    .flush_wfid    (flush_wfid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_wfid      (out_wfid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_long      (out_long),
    .half_rqd      (half_rqd),
    .half_rqd_wfid (half_rqd_wfid),
    .err_pc        (err_pc),
    .pending_count (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what each wavefront holds and what downstream should see.
  bit          m_pend  [NUM_WF];
  logic [31:0] m_instr [NUM_WF];
  logic [31:0] m_pc    [NUM_WF];
  bit          m_ov;
  logic [5:0]  m_owfid;
  logic [63:0] m_oinstr;
  logic [31:0] m_opc;
  bit          m_olong;
  bit          m_hr;
  logic [5:0]  m_hrw;
  bit          m_err;

  function automatic int model_count();
    int c = 0;
    foreach (m_pend[i]) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_ov = 0; m_owfid = '0; m_oinstr = '0; m_opc = '0; m_olong = 0;
    m_hr = 0; m_hrw = '0; m_err = 0;
  endtask

  task automatic observe();
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_wfid", out_wfid, m_owfid);
      check("out_instr", out_instr, m_oinstr);
      check("out_pc", out_pc, m_opc);
      check("out_long", out_long, m_olong);
    end
    check("half_rqd", half_rqd, m_hr);
    if (m_hr) check("half_rqd_wfid", half_rqd_wfid, m_hrw);
    check("err_pc", err_pc, m_err);
    check("pending_count", pending_count, model_count());
  endtask

  // Drive one cycle of inputs and advance the model to the state after the next edge.
  task automatic drive(input bit iv, input int iw, input logic [31:0] ii, input logic [31:0] ip,
                       input bit il, input bit fv, input int fw, input bit ordy);
    bit rdy, acc, fok, iok, consumed, dropped, load;
    in_valid = iv; in_wfid = iw[5:0]; in_instr = ii; in_pc = ip; in_long = il;
    flush_valid = fv; flush_wfid = fw[5:0]; out_ready = ordy;
    #1;
    rdy = !m_ov || ordy;
    check("in_ready", in_ready, rdy);
    acc      = iv && rdy;
    fok      = fv && (fw < NUM_WF);
    iok      = iw < NUM_WF;
    consumed = m_ov && ordy;
    dropped  = fok && m_ov && (m_owfid == fw[5:0]);
    load     = 0;
    m_hr     = 0;
    m_err    = 0;
    if (acc && iok && !(fok && fw == iw)) begin
      if (m_pend[iw]) begin
        load     = 1;
        m_oinstr = {ii, m_instr[iw]};
        m_opc    = m_pc[iw];
        m_olong  = 1;
        m_err    = (ip != m_pc[iw] + 32'(PC_STEP));
        m_pend[iw] = 0;
      end else if (il) begin
        m_pend[iw]  = 1;
        m_instr[iw] = ii;
        m_pc[iw]    = ip;
        m_hr        = 1;
        m_hrw       = iw[5:0];
      end else begin
        load     = 1;
        m_oinstr = {32'h0, ii};
        m_opc    = ip;
        m_olong  = 0;
      end
      if (load) m_owfid = iw[5:0];
    end
    if (fok) m_pend[fw] = 0;
    if (load) m_ov = 1;
    else if (consumed || dropped) m_ov = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_wfid = '0; in_instr = '0; in_pc = '0; in_long = 0;
    flush_valid = 0; flush_wfid = '0; out_ready = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_instr"}, out_instr, 0);
    check({tag, "_out_pc"}, out_pc, 0);
    check({tag, "_out_wfid"}, out_wfid, 0);
    check({tag, "_out_long"}, out_long, 0);
    check({tag, "_half_rqd"}, half_rqd, 0);
    check({tag, "_half_rqd_wfid"}, half_rqd_wfid, 0);
    check({tag, "_err_pc"}, err_pc, 0);
    check({tag, "_pending_count"}, pending_count, 0);
  endtask

  logic [63:0] held_instr;
  int          iw, fw;
  logic [31:0] ip;

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_in_ready", in_ready, 1);
    rst = 1'b1;

    // Short word.
    drive(1, 3, 32'hA000_0003, 32'h100, 0, 0, 0, 1);
    observe();
    check("short_valid", out_valid, 1);
    check("short_wfid", out_wfid, 3);
    check("short_long", out_long, 0);
    check("short_upper", out_instr[63:32], 0);

    // Interleaved first half / short / second half.
    drive(1, 5, 32'hB000_0005, 32'h200, 1, 0, 0, 1);
    observe();
    check("first_half_rqd", half_rqd, 1);
    check("first_half_wfid", half_rqd_wfid, 5);
    check("first_pending", pending_count, 1);
    drive(1, 7, 32'hC000_0007, 32'h300, 0, 0, 0, 1);
    observe();
    check("interleave_short_wfid", out_wfid, 7);
    check("interleave_no_rqd", half_rqd, 0);
    drive(1, 5, 32'hD000_0005, 32'h204, 0, 0, 0, 1);
    observe();
    check("second_long", out_long, 1);
    check("second_pc", out_pc, 32'h200);
    check("second_instr", out_instr, 64'hD000_0005_B000_0005);
    check("second_pending", pending_count, 0);
    check("second_no_err", err_pc, 0);

    // PC discontinuity.
    drive(1, 2, 32'h1111_2222, 32'h40, 1, 0, 0, 1);
    observe();
    drive(1, 2, 32'h3333_4444, 32'h50, 1, 0, 0, 1);
    observe();
    check("pcerr_valid", out_valid, 1);
    check("pcerr_pulse", err_pc, 1);

    // Backpressure: output held, word retried until accepted.
    held_instr = out_instr;
    for (int k = 0; k < 4; k++) begin
      drive(1, 4, 32'h4444_0004, 32'h400, 0, 0, 0, 0);
      observe();
      check("bp_hold_instr", out_instr, held_instr);
      check("bp_hold_wfid", out_wfid, 2);
    end
    drive(1, 4, 32'h4444_0004, 32'h400, 0, 0, 0, 1);
    observe();
    check("bp_release_wfid", out_wfid, 4);

    // Flush colliding with a second half.
    drive(1, 9, 32'h9999_0001, 32'h900, 1, 0, 0, 1);
    observe();
    check("flush_pre_pending", pending_count, 1);
    drive(1, 9, 32'h9999_0002, 32'h904, 0, 1, 9, 1);
    observe();
    check("flush_no_out", out_valid, 0);
    check("flush_pending", pending_count, 0);
    drive(1, 9, 32'h9999_0003, 32'h908, 0, 0, 0, 1);
    observe();
    check("flush_fresh_short", out_long, 0);
    check("flush_fresh_wfid", out_wfid, 9);

    // Asynchronous reset with three pending slots.
    for (int w = 10; w < 13; w++) begin
      drive(1, w, 32'h5500_0000 + 32'(w), 32'h1000 + 32'(w * 16), 1, 0, 0, 1);
      observe();
    end
    check("rst_pre_pending", pending_count, 3);
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(1, 10, 32'h6600_0010, 32'h2000, 0, 0, 0, 1);
    observe();
    check("post_rst_short", out_long, 0);
    check("post_rst_valid", out_valid, 1);
    drive(1, 11, 32'h6600_0011, 32'h2100, 1, 0, 0, 1);
    observe();
    check("post_rst_first", half_rqd, 1);
    drive(1, 11, 32'h6600_0012, 32'h2104, 0, 0, 0, 1);
    observe();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      iw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(38, 63)) : int'($urandom_range(0, 7));
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(38, 63)) : int'($urandom_range(0, 7));
      if (iw < NUM_WF && m_pend[iw] && $urandom_range(0, 3) != 0) ip = m_pc[iw] + 32'(PC_STEP);
      else ip = $urandom;
      drive($urandom_range(0, 4) != 0, iw, $urandom, ip, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, fw, $urandom_range(0, 9) < 7);
      observe();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
